// File: rtl/snake_pkg.sv
// Shared constants for the snake game front end: default divider ratios,
// debounce depth and the button index map used by ButtonsHeld.
package snake_pkg;

  localparam int CLK_DIV_DEF     = 2;
  localparam int GAME_DIV_DEF    = 12_500_000;
  localparam int FAST_DIV_DEF    = 50_000;
  localparam int DEB_SAMPLES_DEF = 8;

  localparam int NUM_BUTTONS = 5;
  localparam int BTN_LEFT    = 0;
  localparam int BTN_RIGHT   = 1;
  localparam int BTN_UP      = 2;
  localparam int BTN_DOWN    = 3;
  localparam int BTN_CENTER  = 4;

  typedef enum logic {
    BTN_RELEASED = 1'b0,
    BTN_HELD     = 1'b1
  } btn_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Single push-button debouncer: counts consecutive disagreeing samples taken on
// SampleEn and emits a one-cycle press pulse. Optional DEBOUNCE_SYNC_EN adds a 2-flop synchronizer.
module button_debouncer
  import snake_pkg::*;
#(
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
  input  logic MasterClock,
  input  logic ResetN,
  input  logic SampleEn,
  input  logic Raw,
  output logic Held,
  output logic Pressed
);

  localparam int CW = (DEB_SAMPLES < 1) ? 1 : $clog2(DEB_SAMPLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_SAMPLES - 1);

  logic sample;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge MasterClock or negedge ResetN) begin
    if (!ResetN) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], Raw};
  end
  assign sample = sync_q[1];
`else
  assign sample = Raw;
`endif

  btn_state_e    state;
  logic [CW-1:0] count;
  logic          held_q;

  // Pressed lags the stable-level change by one cycle via held_q
  always_ff @(posedge MasterClock or negedge ResetN) begin
    if (!ResetN) begin
      state   <= BTN_RELEASED;
      count   <= '0;
      held_q  <= 1'b0;
      Pressed <= 1'b0;
    end else begin
      held_q  <= (state == BTN_HELD);
      Pressed <= (state == BTN_HELD) && !held_q;
      if (SampleEn) begin
        if (sample == state) begin
          count <= '0;
        end else if (count == LAST) begin
          state <= btn_state_e'(sample);
          count <= '0;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

  assign Held = (state == BTN_HELD);

endmodule

// File: rtl/clk_div_debounce.sv
// Timing/input front end: pixel, game-step and refresh square waves with rise ticks,
// plus five debounced buttons sampled on FastTick. Optional feature macro: DEBOUNCE_SYNC_EN.
module clk_div_debounce
  import snake_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int GAME_DIV    = GAME_DIV_DEF,
  parameter int FAST_DIV    = FAST_DIV_DEF,
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
  input  logic       MasterClock,
  input  logic       ResetN,
  input  logic       ButtonLeft,
  input  logic       ButtonRight,
  input  logic       ButtonUp,
  input  logic       ButtonDown,
  input  logic       ButtonCenter,
  output logic       Clock,
  output logic       GameClock,
  output logic       FastClock,
  output logic       ClockTick,
  output logic       GameTick,
  output logic       FastTick,
  output logic       LeftPressed,
  output logic       RightPressed,
  output logic       UpPressed,
  output logic       DownPressed,
  output logic       CenterPressed,
  output logic [4:0] ButtonsHeld
);

  localparam int CLK_W  = $clog2(CLK_DIV + 1);
  localparam int GAME_W = $clog2(GAME_DIV + 1);
  localparam int FAST_W = $clog2(FAST_DIV + 1);

  logic [CLK_W-1:0]  clk_cnt;
  logic [GAME_W-1:0] game_cnt;
  logic [FAST_W-1:0] fast_cnt;

  // Each tick fires on the wrap that takes its wave from 0 to 1
  always_ff @(posedge MasterClock or negedge ResetN) begin
    if (!ResetN) begin
      clk_cnt   <= '0;
      Clock     <= 1'b0;
      ClockTick <= 1'b0;
    end else begin
      ClockTick <= 1'b0;
      if (clk_cnt == CLK_W'(CLK_DIV - 1)) begin
        clk_cnt   <= '0;
        Clock     <= ~Clock;
        ClockTick <= ~Clock;
      end else begin
        clk_cnt <= clk_cnt + CLK_W'(1);
      end
    end
  end

  always_ff @(posedge MasterClock or negedge ResetN) begin
    if (!ResetN) begin
      game_cnt  <= '0;
      GameClock <= 1'b0;
      GameTick  <= 1'b0;
    end else begin
      GameTick <= 1'b0;
      if (game_cnt == GAME_W'(GAME_DIV - 1)) begin
        game_cnt  <= '0;
        GameClock <= ~GameClock;
        GameTick  <= ~GameClock;
      end else begin
        game_cnt <= game_cnt + GAME_W'(1);
      end
    end
  end

  always_ff @(posedge MasterClock or negedge ResetN) begin
    if (!ResetN) begin
      fast_cnt  <= '0;
      FastClock <= 1'b0;
      FastTick  <= 1'b0;
    end else begin
      FastTick <= 1'b0;
      if (fast_cnt == FAST_W'(FAST_DIV - 1)) begin
        fast_cnt  <= '0;
        FastClock <= ~FastClock;
        FastTick  <= ~FastClock;
      end else begin
        fast_cnt <= fast_cnt + FAST_W'(1);
      end
    end
  end

  logic [NUM_BUTTONS-1:0] raw;
  logic [NUM_BUTTONS-1:0] pressed;

  assign raw = {ButtonCenter, ButtonDown, ButtonUp, ButtonRight, ButtonLeft};

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debouncer #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
      .MasterClock (MasterClock),
      .ResetN      (ResetN),
      .SampleEn    (FastTick),
      .Raw         (raw[i]),
      .Held        (ButtonsHeld[i]),
      .Pressed     (pressed[i])
    );
  end

  assign LeftPressed   = pressed[BTN_LEFT];
  assign RightPressed  = pressed[BTN_RIGHT];
  assign UpPressed     = pressed[BTN_UP];
  assign DownPressed   = pressed[BTN_DOWN];
  assign CenterPressed = pressed[BTN_CENTER];

endmodule

// File: tb/tb_clk_div_debounce.sv
// Directed bench for clk_div_debounce: divider start-up table, tick counts, and
// debounce corner cases on a DEB_SAMPLES=3 instance plus a DEB_SAMPLES=1 instance.
module tb_clk_div_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0, bc = 1'b0;

  logic       Clock, GameClock, FastClock, ClockTick, GameTick, FastTick;
  logic       LeftPressed, RightPressed, UpPressed, DownPressed, CenterPressed;
  logic [4:0] ButtonsHeld;

  logic       c1_clk, c1_game, c1_fast, c1_ctick, c1_gtick, c1_ftick;
  logic       c1_lp, c1_rp, c1_up, c1_dp, c1_cp;
  logic [4:0] c1_held;

  clk_div_debounce #(.CLK_DIV(2), .GAME_DIV(10), .FAST_DIV(4), .DEB_SAMPLES(3)) dut (
    .MasterClock(clk), .ResetN(rst_n),
    .ButtonLeft(bl), .ButtonRight(br), .ButtonUp(bu), .ButtonDown(bd), .ButtonCenter(bc),
    .Clock(Clock), .GameClock(GameClock), .FastClock(FastClock),
    .ClockTick(ClockTick), .GameTick(GameTick), .FastTick(FastTick),
    .LeftPressed(LeftPressed), .RightPressed(RightPressed), .UpPressed(UpPressed),
    .DownPressed(DownPressed), .CenterPressed(CenterPressed), .ButtonsHeld(ButtonsHeld)
  );

  clk_div_debounce #(.CLK_DIV(2), .GAME_DIV(10), .FAST_DIV(4), .DEB_SAMPLES(1)) dut1 (
    .MasterClock(clk), .ResetN(rst_n),
    .ButtonLeft(bl), .ButtonRight(br), .ButtonUp(bu), .ButtonDown(bd), .ButtonCenter(bc),
    .Clock(c1_clk), .GameClock(c1_game), .FastClock(c1_fast),
    .ClockTick(c1_ctick), .GameTick(c1_gtick), .FastTick(c1_ftick),
    .LeftPressed(c1_lp), .RightPressed(c1_rp), .UpPressed(c1_up),
    .DownPressed(c1_dp), .CenterPressed(c1_cp), .ButtonsHeld(c1_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] btn;   // {C,D,U,R,L}
    logic [5:0] exp;   // {Clock,ClockTick,FastClock,FastTick,GameClock,GameTick}
  } vec_t;

  vec_t tbl[12];
  int   total = 0;
  int   bad = 0;

  logic [4:0] pv;
  assign pv = {CenterPressed, DownPressed, UpPressed, RightPressed, LeftPressed};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after a debounce sampling edge
  task automatic sync_sample();
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (FastTick) found = 1;
    end
    check("fast_tick_seen", 32'(found), 32'd1);
    tick1();
  endtask

  task automatic watch(input int ncyc, input int btn, input logic target,
                       output int npulse, output int pcyc, output int hcyc, output int other);
    npulse = 0; pcyc = -1; hcyc = -1; other = 0;
    for (int c = 1; c <= ncyc; c++) begin
      tick1();
      if (pv[btn]) begin
        npulse++;
        if (pcyc < 0) pcyc = c;
      end
      if ((pv & ~(5'b1 << btn)) != 5'b0) other++;
      if (hcyc < 0 && ButtonsHeld[btn] == target) hcyc = c;
    end
  endtask

  initial begin
    int np, pc, hc, oth;
    int n_ct, n_gt, n_ft, align_err;
    logic pc_clk, pc_game, pc_fast;
    int rp, cp, rpc, cpc, lbad, np1, pc1;

    for (int i = 0; i < 12; i++) tbl[i].btn = 5'b0;
    tbl[0].exp  = 6'b000000; tbl[1].exp  = 6'b110000; tbl[2].exp  = 6'b100000;
    tbl[3].exp  = 6'b001100; tbl[4].exp  = 6'b001000; tbl[5].exp  = 6'b111000;
    tbl[6].exp  = 6'b101000; tbl[7].exp  = 6'b000000; tbl[8].exp  = 6'b000000;
    tbl[9].exp  = 6'b110011; tbl[10].exp = 6'b100010; tbl[11].exp = 6'b001110;

    // Reset held for 5 cycles: every output low
    for (int i = 0; i < 5; i++) begin
      tick1();
      check("reset_outputs",
            32'({Clock, GameClock, FastClock, ClockTick, GameTick, FastTick, pv, ButtonsHeld}), 32'd0);
    end
    rst_n = 1'b1;

    // Start-up table plus tick counting over 400 cycles
    n_ct = 0; n_gt = 0; n_ft = 0; align_err = 0;
    pc_clk = 0; pc_game = 0; pc_fast = 0;
    for (int n = 1; n <= 400; n++) begin
      if (n <= 12) {bc, bd, bu, br, bl} = tbl[n-1].btn;
      tick1();
      if (n <= 12)
        check($sformatf("startup_n%0d", n),
              32'({Clock, ClockTick, FastClock, FastTick, GameClock, GameTick}), 32'(tbl[n-1].exp));
      n_ct += int'(ClockTick); n_gt += int'(GameTick); n_ft += int'(FastTick);
      if (ClockTick != (Clock && !pc_clk))    align_err++;
      if (GameTick  != (GameClock && !pc_game)) align_err++;
      if (FastTick  != (FastClock && !pc_fast)) align_err++;
      pc_clk = Clock; pc_game = GameClock; pc_fast = FastClock;
    end
    check("clock_tick_count", 32'(n_ct), 32'd100);
    check("game_tick_count",  32'(n_gt), 32'd20);
    check("fast_tick_count",  32'(n_ft), 32'd50);
    check("tick_alignment",   32'(align_err), 32'd0);

    // Clean press of Up
    sync_sample();
    bu = 1'b1;
    watch(200, 2, 1'b1, np, pc, hc, oth);
    check("up_pulse_count", 32'(np), 32'd1);
    check("up_pulse_cycle", 32'(pc), 32'd25);
    check("up_held_cycle",  32'(hc), 32'd24);
    check("up_other_pulses", 32'(oth), 32'd0);
    check("held_up", 32'(ButtonsHeld), 32'b00100);

    // Release of Up: level drops after 3 samples, no pulse
    sync_sample();
    bu = 1'b0;
    watch(60, 2, 1'b0, np, pc, hc, oth);
    check("release_pulses", 32'(np + oth), 32'd0);
    check("release_held_cycle", 32'(hc), 32'd24);

    // Bounce on Left between consecutive samples
    sync_sample();
    lbad = 0;
    for (int t = 0; t < 10; t++) begin
      bl = (t % 2 == 0);
      for (int c = 0; c < 8; c++) begin
        tick1();
        if (LeftPressed || ButtonsHeld[0]) lbad++;
      end
    end
    check("bounce_no_accept", 32'(lbad), 32'd0);
    bl = 1'b1;
    watch(60, 0, 1'b1, np, pc, hc, oth);
    check("bounce_then_pulse_count", 32'(np), 32'd1);
    check("bounce_then_pulse_cycle", 32'(pc), 32'd25);

    // Right and Center together
    sync_sample();
    br = 1'b1; bc = 1'b1;
    rp = 0; cp = 0; rpc = -1; cpc = -1; oth = 0;
    for (int c = 1; c <= 60; c++) begin
      tick1();
      if (RightPressed)  begin rp++; if (rpc < 0) rpc = c; end
      if (CenterPressed) begin cp++; if (cpc < 0) cpc = c; end
      if (LeftPressed || UpPressed || DownPressed) oth++;
    end
    check("simul_right_cycle",  32'(rpc), 32'd25);
    check("simul_center_cycle", 32'(cpc), 32'd25);
    check("simul_pulse_counts", 32'(rp + cp), 32'd2);
    check("simul_others", 32'(oth), 32'd0);
    check("simul_held", 32'(ButtonsHeld), 32'b10011);

    bl = 1'b0; br = 1'b0; bc = 1'b0;
    for (int c = 0; c < 40; c++) tick1();
    check("all_released", 32'({ButtonsHeld, c1_held}), 32'd0);

    // Async reset while Down is qualifying
    sync_sample();
    bd = 1'b1;
    for (int c = 0; c < 10; c++) tick1();
    check("mid_qual_not_held", 32'(ButtonsHeld[3]), 32'd0);
    check("deb1_held_before_reset", 32'(c1_held[3]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({Clock, GameClock, FastClock, ClockTick, GameTick, FastTick, pv, ButtonsHeld, c1_held}), 32'd0);
    for (int c = 0; c < 5; c++) tick1();
    rst_n = 1'b1;
    np = 0; pc = -1; np1 = 0; pc1 = -1;
    for (int n = 1; n <= 100; n++) begin
      tick1();
      if (DownPressed) begin np++; if (pc < 0) pc = n; end
      if (c1_dp) begin np1++; if (pc1 < 0) pc1 = n; end
    end
    check("requal_pulse_count", 32'(np), 32'd1);
    check("requal_pulse_cycle", 32'(pc), 32'd22);
    check("deb1_requal_count",  32'(np1), 32'd1);
    check("deb1_requal_cycle",  32'(pc1), 32'd6);
    bd = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
